// File: rtl/gcd_feeder.sv
// gcd_feeder: valid/ready front end for a single gcd core.
// Operand pairs queue in a DEPTH-entry FIFO and go to the core one at a time.
// Each result (or a watchdog abort) is held on the output port until accepted.
module gcd_feeder #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic                     core_start,
  output logic [WIDTH-1:0]         core_a,
  output logic [WIDTH-1:0]         core_b,
  input  logic [WIDTH-1:0]         core_outp,
  input  logic                     core_done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_gcd,
  output logic                     out_timeout,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pair_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  pair_t         mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          push, pop, full, empty;

  state_t           state, state_n;
  logic [TW-1:0]    timer, timer_n;
  logic             cs_n, ov_n, ot_n;
  logic [WIDTH-1:0] ca_n, cb_n, og_n;

  // full gates acceptance, so a pop in the same cycle never frees a slot early
  assign full       = (count == FULL);
  assign empty      = (count == '0);
  assign in_ready   = !full && !reset;
  assign push       = in_valid && in_ready;
  assign fifo_count = count;

  // FIFO storage; contents are don't-care while empty, so no reset
  always_ff @(posedge clock) begin
    if (push) mem[wptr] <= '{a: in_a, b: in_b};
  end

  // FIFO pointers and occupancy; pointer width makes wrap modulo DEPTH
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FSM state, watchdog timer and all registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      core_start  <= 1'b0;
      core_a      <= '0;
      core_b      <= '0;
      out_valid   <= 1'b0;
      out_gcd     <= '0;
      out_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      core_start  <= cs_n;
      core_a      <= ca_n;
      core_b      <= cb_n;
      out_valid   <= ov_n;
      out_gcd     <= og_n;
      out_timeout <= ot_n;
    end
  end

  // next state / next outputs; start is set on the pop so it is high only in ISSUE
  always_comb begin
    state_n = state;
    timer_n = timer;
    pop     = 1'b0;
    cs_n    = 1'b0;
    ca_n    = core_a;
    cb_n    = core_b;
    ov_n    = out_valid;
    og_n    = out_gcd;
    ot_n    = out_timeout;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          ca_n    = mem[rptr].a;
          cb_n    = mem[rptr].b;
          cs_n    = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        timer_n = '0;
        state_n = WAIT;
      end
      WAIT: begin
        // done has priority over an expiring watchdog
        if (core_done) begin
          og_n    = core_outp;
          ot_n    = 1'b0;
          ov_n    = 1'b1;
          state_n = HOLD;
        end else if (timer == TLAST) begin
          og_n    = '0;
          ot_n    = 1'b1;
          ov_n    = 1'b1;
          state_n = HOLD;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          ov_n    = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gcd_feeder.sv
// Scoreboard bench for gcd_feeder with a behavioural gcd core model.
module tb_gcd_feeder;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int TO = 16;

  logic clock = 0, reset = 1;
  logic in_valid = 0, out_ready = 0, core_done = 0;
  logic [W-1:0] in_a = 0, in_b = 0, core_outp = 0;
  logic in_ready, core_start, out_valid, out_timeout;
  logic [W-1:0] core_a, core_b, out_gcd;
  logic [$clog2(D):0] fifo_count;

  always #5 clock = ~clock;

  gcd_feeder #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .core_start(core_start), .core_a(core_a),
    .core_b(core_b), .core_outp(core_outp), .core_done(core_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd),
    .out_timeout(out_timeout), .fifo_count(fifo_count)
  );

  typedef struct { logic [W-1:0] g; logic to; } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0, start_cnt = 0;
  bit hang = 0, rand_rdy = 0;

  // gcd as the core defines it: any zero operand yields 0
  function automatic logic [W-1:0] ref_gcd(input int a, input int b);
    int t;
    if (a == 0 || b == 0) return '0;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a[W-1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // core model: random latency, optional hang, spurious done pulses while result held
  initial begin : core_model
    logic [W-1:0] ca, cb;
    logic [31:0] r;
    int lat;
    bit abort;
    forever begin
      @(posedge clock); #1;
      core_done = 0;
      if (reset) continue;
      if (core_start) begin
        if (!hang) begin
          ca = core_a; cb = core_b; lat = $urandom_range(1, 8); abort = 0;
          repeat (lat) begin @(posedge clock); #1; if (reset) abort = 1; end
          if (!abort) begin core_done = 1; core_outp = ref_gcd(ca, cb); end
        end
      end else if (out_valid && $urandom_range(0, 3) == 0) begin
        r = $urandom; core_done = 1; core_outp = r[W-1:0];
      end
    end
  end

  initial begin : rdy_gen
    forever begin
      @(posedge clock); #1;
      if (rand_rdy) out_ready = $urandom_range(0, 1);
    end
  end

  // monitor: pops expected results on each handshake, checks hold stability
  initial begin : monitor
    logic pv, phs, pt, pcs;
    logic [W-1:0] pg;
    exp_t e;
    pv = 0; phs = 0; pt = 0; pcs = 0; pg = 0;
    forever begin
      @(negedge clock);
      if (reset) begin pv = 0; phs = 0; pcs = 0; continue; end
      if (core_start) begin
        start_cnt++;
        chk("start_single_cycle", pcs, 0);
      end
      if (pv && !phs) begin
        chk("valid_held", out_valid, 1);
        chk("gcd_stable", out_gcd, pg);
        chk("timeout_stable", out_timeout, pt);
      end
      if (out_valid) chk("no_start_in_hold", core_start, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result: got gcd=%0d timeout=%0d with nothing pending", out_gcd, out_timeout);
        end else begin
          e = sb.pop_front();
          chk("out_gcd", out_gcd, e.g);
          chk("out_timeout", out_timeout, e.to);
        end
      end
      pv = out_valid; phs = out_valid && out_ready; pg = out_gcd; pt = out_timeout; pcs = core_start;
    end
  end

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    exp_t e;
    n = 0;
    in_valid = 1; in_a = a; in_b = b;
    forever begin
      @(negedge clock);
      if (in_ready) break;
      n++;
      if (n > 300) break;
    end
    if (n > 300) begin
      total++; bad++;
      $display("FAIL push_wait: in_ready stayed 0, required 1 within 300 cycles");
    end else begin
      e.g  = hang ? '0 : ref_gcd(a, b);
      e.to = hang;
      sb.push_back(e);
    end
    @(posedge clock); #1;
    in_valid = 0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin @(negedge clock); n++; end
    chk("drain_pending", sb.size(), 0);
    @(posedge clock); #1;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    forever begin
      @(negedge clock);
      if (out_valid) break;
      n++;
      if (n > budget) break;
    end
    if (n > budget) begin
      total++; bad++;
      $display("FAIL wait_valid: out_valid 0, required 1 within %0d cycles", budget);
    end
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1;
    sb.delete();
    @(negedge clock);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready2", in_ready, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_gcd", out_gcd, 0);
    chk("rst_out_timeout", out_timeout, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_ab", {core_a, core_b}, 0);
    @(posedge clock); #1;
    reset = 0;
    @(negedge clock);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clock); #1;
  endtask

  initial begin : guard
    #2000000;
    $display("FAIL global_time_limit: bench did not finish");
    $fatal(1, "time limit");
  end

  initial begin : main
    int s, cs_cyc, ov_cyc, n;
    logic [31:0] ra, rb;
    do_reset();

    // 1: single request
    out_ready = 1;
    s = start_cnt;
    push(12, 8);
    drain(100);
    @(negedge clock);
    chk("t1_fifo_empty", fifo_count, 0);
    chk("t1_one_start", start_cnt - s, 1);
    @(posedge clock); #1;

    // 3 + 2: result held 20 cycles while four pairs fill the FIFO
    out_ready = 0;
    push(100, 75);
    wait_valid(60);
    s = start_cnt;
    push(48, 18); push(7, 5); push(0, 9); push(255, 85);
    @(negedge clock);
    chk("t2_in_ready_full", in_ready, 0);
    chk("t2_count_full", fifo_count, 4);
    repeat (20) @(negedge clock);
    chk("t3_no_issue_in_hold", start_cnt - s, 0);
    @(posedge clock); #1;
    out_ready = 1;
    drain(300);
    chk("t3_issues_after_release", start_cnt - s, 4);

    // 4: hung core; the pulse is one cycle, then WAIT spans TIMEOUT cycles
    hang = 1;
    push(20, 10);
    n = 0;
    forever begin @(negedge clock); if (core_start || n > 50) break; n++; end
    cs_cyc = cyc;
    n = 0;
    forever begin @(negedge clock); if (out_valid || n > 100) break; n++; end
    ov_cyc = cyc;
    chk("t4_timeout_latency", ov_cyc - cs_cyc, TO + 1);
    @(posedge clock); #1;
    drain(50);
    hang = 0;
    push(21, 14);
    drain(100);

    // 5: reset while waiting with two pairs queued
    hang = 1;
    push(30, 12); push(40, 16); push(50, 20);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("t5_queued", fifo_count, 2);
    do_reset();
    hang = 0;
    repeat (30) @(posedge clock);
    #1;
    push(9, 6);
    drain(100);

    // 6: full FIFO, held push, same-cycle pop
    out_ready = 0;
    push(60, 45);
    wait_valid(60);
    push(14, 21); push(0, 0); push(200, 100); push(17, 51);
    fork
      push(81, 27);
      begin
        @(negedge clock);
        chk("t6_full_no_push", fifo_count, 4);
        @(posedge clock); #1;
        out_ready = 1;
        @(posedge clock); #1;
        out_ready = 0;
        @(negedge clock);
        chk("t6_before_pop", fifo_count, 4);
        @(negedge clock);
        chk("t6_pop_no_push", fifo_count, 3);
        @(negedge clock);
        chk("t6_push_lands", fifo_count, 4);
      end
    join
    out_ready = 1;
    drain(400);

    // random traffic with random back-pressure
    rand_rdy = 1;
    for (int i = 0; i < 60; i++) begin
      ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 0;
      if ($urandom_range(0, 7) == 0) rb = 0;
      push(ra[W-1:0], rb[W-1:0]);
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
    end
    rand_rdy = 0;
    out_ready = 1;
    drain(3000);

    chk("final_scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
